// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- UART receiver (8N1, optionally 8E1)
//
// Receives the serial stream produced by uart_tx. The line passes through a
// two-flop synchronizer, and every bit is sampled in the middle of its bit
// period. The byte arrives LSB first and is rebuilt in a shift register. A good
// frame is presented on dout_o together with a one-cycle rx_done_tick_o. A
// stop bit sampled low raises a one-cycle frame_err_o and leaves dout_o as it
// was.
//
// Configuration macro: UART_RX_PARITY_EN
//   defined     : 8E1 frame. An even parity bit follows the data bits. A
//                 mismatch pulses parity_err_o together with rx_done_tick_o,
//                 and the byte is still delivered.
//   not defined : 8N1 frame. parity_err_o is tied to 0.
//
// Ports
//   clk             in   1  system clock, rising edge
//   rst_n           in   1  asynchronous, active-low reset
//   rx_i            in   1  serial line, asynchronous to clk, idles high
//   dout_o          out  8  last correctly framed byte
//   rx_done_tick_o  out  1  1-cycle pulse: byte valid on dout_o
//   frame_err_o     out  1  1-cycle pulse: stop bit sampled low
//   parity_err_o    out  1  1-cycle pulse with rx_done_tick_o on parity mismatch
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int c_clkfreq  = 100_000_000,
    parameter int c_baudrate = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] dout_o,
    output logic       rx_done_tick_o,
    output logic       frame_err_o,
    output logic       parity_err_o
);

    localparam int c_bittimerlim = c_clkfreq / c_baudrate;
    localparam int c_tw          = $clog2(c_bittimerlim);
    // Last timer value of a full bit period and of a half bit period.
    localparam logic [c_tw-1:0] c_bit_last  = c_tw'(c_bittimerlim - 1);
    localparam logic [c_tw-1:0] c_half_last = c_tw'(c_bittimerlim / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity holds when the data bits and the parity bit together have an
    // even number of ones. Any odd total is an error.
    function automatic logic even_parity_err(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction
`endif

    logic            sync1_r;
    logic            sync2_r;
    logic            rx_s;
    state_t          state_r;
    state_t          state_s;
    logic [c_tw-1:0] timer_r;
    logic [c_tw-1:0] timer_s;
    logic [2:0]      count_r;
    logic [2:0]      count_s;
    logic [7:0]      shreg_r;
    logic [7:0]      shreg_s;
    logic [7:0]      dout_r;
    logic [7:0]      dout_s;
    logic            tick_r;
    logic            tick_s;
    logic            ferr_r;
    logic            ferr_s;
`ifdef UART_RX_PARITY_EN
    logic            par_r;
    logic            par_s;
    logic            perr_r;
    logic            perr_s;
`endif

    // Two-flop synchronizer. It resets to the idle level so that no false
    // start edge appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_i;
            sync2_r <= sync1_r;
        end
    end

    assign rx_s = sync2_r;

    // State, bit timer, data path and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            timer_r <= '0;
            count_r <= 3'd0;
            shreg_r <= 8'h00;
            dout_r  <= 8'h00;
            tick_r  <= 1'b0;
            ferr_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_r   <= 1'b0;
            perr_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            count_r <= count_s;
            shreg_r <= shreg_s;
            dout_r  <= dout_s;
            tick_r  <= tick_s;
            ferr_r  <= ferr_s;
`ifdef UART_RX_PARITY_EN
            par_r   <= par_s;
            perr_r  <= perr_s;
`endif
        end
    end

    // Next-state logic. Pulse outputs default low, so every pulse lasts a
    // single cycle.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r + {{(c_tw-1){1'b0}}, 1'b1};
        count_s = count_r;
        shreg_s = shreg_r;
        dout_s  = dout_r;
        tick_s  = 1'b0;
        ferr_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_s   = par_r;
        perr_s  = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                timer_s = '0;
                count_s = 3'd0;
                if (!rx_s) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                // Re-check at mid start bit. A pulse shorter than half a bit
                // is treated as a glitch.
                if (timer_r == c_half_last) begin
                    timer_s = '0;
                    if (rx_s) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    state_s = S_START;
                end
            end
            S_DATA: begin
                if (timer_r == c_bit_last) begin
                    timer_s = '0;
                    // Shift right so the first bit received lands in bit 0.
                    shreg_s = {rx_s, shreg_r[7:1]};
                    count_s = count_r + 3'd1;
                    if (count_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    state_s = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (timer_r == c_bit_last) begin
                    timer_s = '0;
                    par_s   = rx_s;
                    state_s = S_STOP;
                end else begin
                    state_s = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                // Return to IDLE at mid stop bit. The receiver is then ready
                // for a following frame that has no idle gap.
                if (timer_r == c_bit_last) begin
                    timer_s = '0;
                    state_s = S_IDLE;
                    if (rx_s) begin
                        dout_s = shreg_r;
                        tick_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_s = even_parity_err(shreg_r, par_r);
`endif
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    state_s = S_STOP;
                end
            end
            default: begin
                state_s = S_IDLE;
                timer_s = '0;
                count_s = 3'd0;
            end
        endcase
    end

    assign dout_o         = dout_r;
    assign rx_done_tick_o = tick_r;
    assign frame_err_o    = ferr_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o   = perr_r;
`else
    assign parity_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed, self-checking bench for uart_rx at default
// parameters. The 100 MHz clock gives 868 clocks per bit, and the line is
// driven with BAUD = 8680 ns per bit. Each task compares DUT outputs against
// hand-computed expected values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BAUD = 8680;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_MIN = 8246 + 868;
`else
    localparam int LAT_MIN = 8246;
`endif
    localparam int LAT_MAX = LAT_MIN + 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i  = 1'b1;
    logic [7:0] dout_o;
    logic       rx_done_tick_o;
    logic       frame_err_o;
    logic       parity_err_o;

    int total = 0;
    int bad   = 0;

    // Clock-cycle counter and event monitor. The counts are cycles with the
    // pulse high, so one pulse per event also proves that each pulse lasts
    // one cycle.
    int         cyc = 0;
    int         tick_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         last_tick_cyc = 0;
    logic [7:0] hist [0:31];
    logic       perr_hist [0:31];

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_i           (rx_i),
        .dout_o         (dout_o),
        .rx_done_tick_o (rx_done_tick_o),
        .frame_err_o    (frame_err_o),
        .parity_err_o   (parity_err_o)
    );

    always #5 clk = ~clk;

    // Count rising edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_done_tick_o === 1'b1) begin
            hist[tick_cnt % 32]      <= dout_o;
            perr_hist[tick_cnt % 32] <= parity_err_o;
            tick_cnt                 <= tick_cnt + 1;
            last_tick_cyc            <= cyc;
        end
        if (frame_err_o === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (parity_err_o === 1'b1) perr_cnt <= perr_cnt + 1;
    end

    // Drive one frame, LSB first. The caller aligns the start to a falling
    // clock edge. Every bit lasts a whole number of clocks, so later frames
    // stay aligned.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx_i = 1'b0;
        #BAUD;
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            #BAUD;
        end
`ifdef UART_RX_PARITY_EN
        rx_i = (^d) ^ par_flip;
        #BAUD;
`endif
        rx_i = stop_bit;
        #BAUD;
        rx_i = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (dout_o !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout_o); end
        total++; if (rx_done_tick_o !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", rx_done_tick_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err_o); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_basic;
        int t0, f0, p0, c0, lat;
        @(negedge clk);
        t0 = tick_cnt; f0 = ferr_cnt; p0 = perr_cnt; c0 = cyc;
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        lat = last_tick_cyc - c0;
        total++; if (tick_cnt - t0 !== 1) begin bad++; $display("FAIL basic_ticks got=%0d exp=1", tick_cnt - t0); end
        total++; if (hist[t0 % 32] !== 8'hA5) begin bad++; $display("FAIL basic_dout got=%h exp=a5", hist[t0 % 32]); end
        total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL basic_ferr got=%0d exp=0", ferr_cnt - f0); end
        total++; if (perr_cnt - p0 !== 0) begin bad++; $display("FAIL basic_perr got=%0d exp=0", perr_cnt - p0); end
        total++; if (lat < LAT_MIN || lat > LAT_MAX) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d..%0d", lat, LAT_MIN, LAT_MAX); end
    endtask

    task automatic test_back_to_back;
        int t0, f0;
        @(negedge clk);
        t0 = tick_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (tick_cnt - t0 !== 2) begin bad++; $display("FAIL b2b_ticks got=%0d exp=2", tick_cnt - t0); end
        total++; if (hist[t0 % 32] !== 8'h3C) begin bad++; $display("FAIL b2b_first got=%h exp=3c", hist[t0 % 32]); end
        total++; if (hist[(t0 + 1) % 32] !== 8'h00) begin bad++; $display("FAIL b2b_second got=%h exp=00", hist[(t0 + 1) % 32]); end
        total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt - f0); end
    endtask

    task automatic test_glitch;
        int t0, f0;
        @(negedge clk);
        t0 = tick_cnt; f0 = ferr_cnt;
        rx_i = 1'b0;
        #2000;
        rx_i = 1'b1;
        repeat (1000) @(negedge clk);
        total++; if (tick_cnt - t0 !== 0) begin bad++; $display("FAIL glitch_ticks got=%0d exp=0", tick_cnt - t0); end
        total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
        @(negedge clk);
        t0 = tick_cnt;
        send_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (tick_cnt - t0 !== 1) begin bad++; $display("FAIL glitch_next_ticks got=%0d exp=1", tick_cnt - t0); end
        total++; if (dout_o !== 8'h5A) begin bad++; $display("FAIL glitch_next_dout got=%h exp=5a", dout_o); end
    endtask

    task automatic test_frame_err;
        int t0, f0;
        @(negedge clk);
        t0 = tick_cnt; f0 = ferr_cnt;
        send_frame(8'hFF, 1'b0);
        #(2 * BAUD);
        total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0); end
        total++; if (tick_cnt - t0 !== 0) begin bad++; $display("FAIL ferr_ticks got=%0d exp=0", tick_cnt - t0); end
        total++; if (dout_o !== 8'h5A) begin bad++; $display("FAIL ferr_dout_hold got=%h exp=5a", dout_o); end
    endtask

    task automatic test_reset_mid;
        int t0;
        @(negedge clk);
        t0 = tick_cnt;
        fork
            send_frame(8'h81, 1'b1);
            begin
                // Middle of data bit 4: start bit plus bits 0..3, then half a bit.
                #(5 * BAUD + BAUD / 2);
                rst_n = 1'b0;
                #1;
                total++; if (dout_o !== 8'h00) begin bad++; $display("FAIL rstmid_dout_in_reset got=%h exp=00", dout_o); end
                #29;
                rst_n = 1'b1;
            end
        join
        total++; if (tick_cnt - t0 !== 0) begin bad++; $display("FAIL rstmid_ticks got=%0d exp=0", tick_cnt - t0); end
        total++; if (dout_o !== 8'h00) begin bad++; $display("FAIL rstmid_dout got=%h exp=00", dout_o); end
        // Let the receiver finish any frame it locked onto after reset, then
        // return to an idle line.
        #(8 * BAUD);
        @(negedge clk);
        t0 = tick_cnt;
        send_frame(8'h42, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (tick_cnt - t0 !== 1) begin bad++; $display("FAIL rstmid_next_ticks got=%0d exp=1", tick_cnt - t0); end
        total++; if (hist[t0 % 32] !== 8'h42) begin bad++; $display("FAIL rstmid_next_dout got=%h exp=42", hist[t0 % 32]); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int t0;
        @(negedge clk);
        t0 = tick_cnt;
        par_flip = 1'b0;
        send_frame(8'hA5, 1'b1);
        par_flip = 1'b1;
        send_frame(8'hA5, 1'b1);
        par_flip = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (tick_cnt - t0 !== 2) begin bad++; $display("FAIL par_ticks got=%0d exp=2", tick_cnt - t0); end
        total++; if (perr_hist[t0 % 32] !== 1'b0) begin bad++; $display("FAIL par_good_perr got=%b exp=0", perr_hist[t0 % 32]); end
        total++; if (perr_hist[(t0 + 1) % 32] !== 1'b1) begin bad++; $display("FAIL par_bad_perr got=%b exp=1", perr_hist[(t0 + 1) % 32]); end
        total++; if (hist[(t0 + 1) % 32] !== 8'hA5) begin bad++; $display("FAIL par_bad_dout got=%h exp=a5", hist[(t0 + 1) % 32]); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
